// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared hazard-controller state encodings and width defaults
package cpu_ctrl_pkg;
    localparam int REG_W_DEF = 6;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: enable-driven up counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);
    // count enabled edges, holding at the maximum value instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall / branch flush controller with perf counters and stall watchdog
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W     = REG_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int STALL_MAX = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             idex_regwrt,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             exwb_regwrt,
    input  logic [REG_W-1:0] exwb_rd,
    input  logic             branch_taken,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             exwb_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_err
);
    localparam int RL_W = $clog2(STALL_MAX + 2);

    ctrl_state_t     st, nxt;
    logic            rs_hit, rt_hit, hazard, hold;
    logic [RL_W-1:0] run_len;

    assign rs_hit = (idex_regwrt && idex_rd == id_rs) || (exwb_regwrt && exwb_rd == id_rs);
    assign rt_hit = (idex_regwrt && idex_rd == id_rt) || (exwb_regwrt && exwb_rd == id_rt);
    assign hazard = id_valid && ((id_uses_rs && rs_hit) || (id_uses_rt && rt_hit));
    assign pc_hold   = hold;
    assign ifid_hold = hold;
    assign state     = st;

    // branch beats hazard; FLUSH and the unused encoding ignore hazard and fall back to RUN
    always_comb begin
        hold        = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        exwb_flush  = 1'b0;
        nxt         = RUN;
        if (branch_taken) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            exwb_flush  = 1'b1;
            nxt         = FLUSH;
        end else if (hazard && (st == RUN || st == STALL)) begin
            hold        = 1'b1;
            idex_bubble = 1'b1;
            nxt         = STALL;
        end
    end

    // state register plus consecutive-STALL watchdog; run_len stops just past the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= RUN;
            run_len   <= '0;
            stall_err <= 1'b0;
        end else begin
            st <= nxt;
            if (st == STALL) begin
                if (run_len <= RL_W'(STALL_MAX)) run_len <= run_len + 1'b1;
                if (run_len >= RL_W'(STALL_MAX)) stall_err <= 1'b1;
            end else begin
                run_len <= '0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (idex_bubble && !branch_taken),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (branch_taken),
        .cnt (flush_cnt)
    );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table, corner sequences and randomized model check
module tb_pipeline_hazard_ctrl;
    localparam int REG_W = 6;
    localparam int CNT_W = 2;
    localparam int SMAX  = 2;
    localparam int CMAX  = 3;

    typedef struct {
        string      name;
        logic       v;
        logic [5:0] rs;
        logic [5:0] rt;
        logic       urs;
        logic       urt;
        logic       exw;
        logic [5:0] exrd;
        logic       wbw;
        logic [5:0] wbrd;
        logic       br;
        logic [4:0] ctrl;
        int         nst;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_uses_rs, id_uses_rt, idex_regwrt, exwb_regwrt, branch_taken;
    logic [REG_W-1:0] id_rs, id_rt, idex_rd, exwb_rd;
    logic             pc_hold, ifid_hold, idex_bubble, ifid_flush, exwb_flush, stall_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int mst, mscnt, mfcnt, mrl, merr;

    vec_t vt[8];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .STALL_MAX(SMAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .idex_regwrt  (idex_regwrt),
        .idex_rd      (idex_rd),
        .exwb_regwrt  (exwb_regwrt),
        .exwb_rd      (exwb_rd),
        .branch_taken (branch_taken),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .exwb_flush   (exwb_flush),
        .state        (state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .stall_err    (stall_err)
    );

    function automatic logic [4:0] ctrl_now();
        return {pc_hold, ifid_hold, idex_bubble, ifid_flush, exwb_flush};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t x);
        id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_uses_rs = x.urs; id_uses_rt = x.urt;
        idex_regwrt = x.exw; idex_rd = x.exrd; exwb_regwrt = x.wbw; exwb_rd = x.wbrd;
        branch_taken = x.br;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        idex_regwrt = 0; idex_rd = 0; exwb_regwrt = 0; exwb_rd = 0; branch_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // reference: a register is "being written" if either downstream stage writes it
    function automatic bit pending(input logic [5:0] idx);
        return (idex_regwrt && idex_rd == idx) || (exwb_regwrt && exwb_rd == idx);
    endfunction

    function automatic bit model_hazard();
        return id_valid && ((id_uses_rs && pending(id_rs)) || (id_uses_rt && pending(id_rt)));
    endfunction

    function automatic logic [4:0] model_ctrl(input int s);
        if (branch_taken) return 5'b00111;
        if (s != 2 && model_hazard()) return 5'b11100;
        return 5'b00000;
    endfunction

    task automatic model_edge();
        logic [4:0] c;
        c = model_ctrl(mst);
        if (branch_taken) mfcnt = (mfcnt == CMAX) ? CMAX : mfcnt + 1;
        else if (c[2]) mscnt = (mscnt == CMAX) ? CMAX : mscnt + 1;
        if (mst == 1) begin
            mrl++;
            if (mrl > SMAX) merr = 1;
        end else begin
            mrl = 0;
        end
        mst = branch_taken ? 2 : (c[4] ? 1 : 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        chk("reset_state", int'(state), 0);
        chk("reset_stall_cnt", int'(stall_cnt), 0);
        chk("reset_flush_cnt", int'(flush_cnt), 0);
        chk("reset_err", int'(stall_err), 0);
        chk("reset_ctrl", int'(ctrl_now()), 0);
        tick();
        rst = 1'b0;

        vt[0] = '{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0};
        vt[1] = '{"rs_ex",       1, 5, 0, 1, 0, 1, 5, 0, 0, 0, 5'b11100, 1};
        vt[2] = '{"rt_wb",       1, 1, 9, 0, 1, 0, 0, 1, 9, 0, 5'b11100, 1};
        vt[3] = '{"rt_unused",   1, 0, 7, 0, 0, 1, 7, 0, 0, 0, 5'b00000, 0};
        vt[4] = '{"invalid",     0, 5, 5, 1, 1, 1, 5, 1, 5, 0, 5'b00000, 0};
        vt[5] = '{"br_hazard",   1, 5, 0, 1, 0, 1, 5, 0, 0, 1, 5'b00111, 2};
        vt[6] = '{"reg0_wb",     1, 0, 3, 1, 0, 0, 2, 1, 0, 0, 5'b11100, 1};
        vt[7] = '{"no_regwrt",   1, 4, 4, 1, 1, 0, 4, 0, 4, 0, 5'b00000, 0};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            drive(vt[i]);
            #1;
            chk({vt[i].name, "_ctrl"}, int'(ctrl_now()), int'(vt[i].ctrl));
            tick();
            chk({vt[i].name, "_next"}, int'(state), vt[i].nst);
        end

        // raw-after-EX then writer moves to WB then retires
        do_reset();
        idle(); id_valid = 1; id_uses_rs = 1; id_rs = 5; idex_regwrt = 1; idex_rd = 5;
        #1;
        chk("raw_ctrl0", int'(ctrl_now()), 5'b11100);
        tick();
        chk("raw_state1", int'(state), 1);
        chk("raw_scnt1", int'(stall_cnt), 1);
        idex_regwrt = 0; exwb_regwrt = 1; exwb_rd = 5;
        #1;
        chk("raw_ctrl1", int'(ctrl_now()), 5'b11100);
        tick();
        chk("raw_state2", int'(state), 1);
        exwb_regwrt = 0;
        #1;
        chk("raw_ctrl2", int'(ctrl_now()), 0);
        tick();
        chk("raw_state3", int'(state), 0);
        chk("raw_scnt3", int'(stall_cnt), 2);
        chk("raw_err3", int'(stall_err), 0);

        // branch arrives while stalled
        do_reset();
        idle(); id_valid = 1; id_uses_rt = 1; id_rt = 3; idex_regwrt = 1; idex_rd = 3;
        tick();
        chk("bst_state", int'(state), 1);
        branch_taken = 1;
        #1;
        chk("bst_ctrl", int'(ctrl_now()), 5'b00111);
        tick();
        chk("bst_state_f", int'(state), 2);
        chk("bst_fcnt", int'(flush_cnt), 1);
        chk("bst_scnt", int'(stall_cnt), 1);
        branch_taken = 0;
        #1;
        chk("bst_flush_ctrl", int'(ctrl_now()), 0);
        tick();
        chk("bst_state_r", int'(state), 0);

        // watchdog: hazard held for four cycles
        do_reset();
        idle(); id_valid = 1; id_uses_rs = 1; id_rs = 2; idex_regwrt = 1; idex_rd = 2;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("wd_err_%0d", i), int'(stall_err), (i == 4) ? 1 : 0);
        end
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("wd_state_after", int'(state), 0);
        chk("wd_err_sticky", int'(stall_err), 1);
        do_reset();
        chk("wd_err_cleared", int'(stall_err), 0);

        // flush counter saturation, then async reset while in FLUSH
        do_reset();
        branch_taken = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_fcnt", int'(flush_cnt), 3);
        chk("sat_state", int'(state), 2);
        branch_taken = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_fcnt", int'(flush_cnt), 0);
        chk("async_scnt", int'(stall_cnt), 0);
        #1;
        rst = 1'b0;
        #1;
        chk("async_ctrl_after", int'(ctrl_now()), 0);
        tick();
        chk("async_state_after", int'(state), 0);

        // randomized run against the reference model
        do_reset();
        mst = 0; mscnt = 0; mfcnt = 0; mrl = 0; merr = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
                mst = 0; mscnt = 0; mfcnt = 0; mrl = 0; merr = 0;
                chk("rnd_rst_state", int'(state), 0);
                chk("rnd_rst_scnt", int'(stall_cnt), 0);
            end
            id_valid = ($urandom_range(0, 7) != 0);
            id_rs = 6'($urandom_range(0, 3));
            id_rt = 6'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom);
            id_uses_rt = 1'($urandom);
            idex_regwrt = 1'($urandom);
            idex_rd = 6'($urandom_range(0, 3));
            exwb_regwrt = 1'($urandom);
            exwb_rd = 6'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 9) == 0);
            #1;
            chk("rnd_ctrl", int'(ctrl_now()), int'(model_ctrl(mst)));
            chk("rnd_state", int'(state), mst);
            chk("rnd_scnt", int'(stall_cnt), mscnt);
            chk("rnd_fcnt", int'(flush_cnt), mfcnt);
            chk("rnd_err", int'(stall_err), merr);
            model_edge();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
